multi_rate_tick_gen: RTL and testbench
======================================

MULTI_RATE_TICK_GEN -- requirements
Module: multi_rate_tick_gen

Interface
REQ-001 Parameter CNT_W, default 27, width of every per-channel counter and divisor.
REQ-002 Parameter NUM_CH, default 3, number of independent tick channels (1..16).
REQ-003 Parameter DIV_INIT, default {27'd100000, 27'd50000000, 27'd100000000}, packed NUM_CH*CNT_W reset divisors; channel i uses slice [i*CNT_W +: CNT_W] (ch0 = 1 Hz, ch1 = 2 Hz, ch2 = 1 kHz at 100 MHz).
REQ-004 Derived CH_W = max(1, clog2(NUM_CH)), the channel-select width.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  run enable; counters advance only while high.
REQ-008 clear  input  1  synchronous restart of all channel phases.
REQ-009 cfg_we  input  1  divisor write strobe.
REQ-010 cfg_ch  input  CH_W  channel addressed by the write.
REQ-011 cfg_div  input  CNT_W  new divisor value.
REQ-012 tick  output  NUM_CH  per-channel one-cycle pulse, registered.
REQ-013 sq  output  NUM_CH  per-channel square wave, toggles on each tick, registered.
REQ-014 cfg_err  output  1  one-cycle pulse flagging a write to cfg_ch >= NUM_CH, registered.

Function
REQ-015 Each channel SHALL hold a divisor register div[i] and a counter cnt[i], both CNT_W bits.
REQ-016 Per channel, on each edge with start=1, div[i]>=1 and no higher-priority event: if cnt[i]==div[i]-1 then cnt[i]<=0 and tick[i]<=1, else cnt[i]<=cnt[i]+1 and tick[i]<=0.
REQ-017 The tick period SHALL be exactly div[i] clock cycles; tick[i] is high for exactly one cycle per period.
REQ-018 div[i]==1 SHALL give tick[i] high on every cycle while start=1; sq[i] then toggles every cycle.
REQ-019 div[i]==0 SHALL disable the channel: cnt[i] held 0, tick[i]=0, sq[i] held.
REQ-020 sq[i] SHALL toggle on the same edge that sets tick[i] (square-wave period 2*div[i]).
REQ-021 start=0 SHALL freeze cnt[i] and sq[i] and force tick[i]<=0; resuming continues from the frozen count.
REQ-022 clear=1 SHALL set all cnt<=0, sq<=0, tick<=0 and leave div unchanged; clear overrides start and config-restart.
REQ-023 cfg_we=1 with cfg_ch<NUM_CH SHALL set div[cfg_ch]<=cfg_div and cnt[cfg_ch]<=0, force tick[cfg_ch]<=0 that edge (write wins over a coincident terminal count), and leave sq and other channels untouched.
REQ-024 A write SHALL take effect regardless of start; the first tick after a write with start held high occurs exactly cfg_div cycles after the write edge.
REQ-025 cfg_we=1 with cfg_ch>=NUM_CH SHALL change no state and set cfg_err<=1 for one cycle; otherwise cfg_err<=0.
REQ-026 Counter arithmetic SHALL be unsigned CNT_W-bit; cnt never exceeds div-1, so no wrap-around occurs.
REQ-027 If div[i] is rewritten below the current cnt[i], the write restart (REQ-023) SHALL prevent any overrun.
REQ-028 Priority per edge: rst > clear > cfg write to that channel > start/count.

Reset
REQ-029 On rst=0 at a clock edge: div[i]<=DIV_INIT slice i, cnt[i]<=0, tick<=0, sq<=0, cfg_err<=0.
REQ-030 rst=0 SHALL override every other input, including cfg_we and clear, on that edge.
REQ-031 Reset asserted mid-period SHALL discard the partial count; after release, the first tick occurs div[i] cycles after the first edge with start=1.

Verification (CNT_W=8, NUM_CH=3, DIV_INIT={8'd2,8'd5,8'd10})
REQ-032 Reset, start=1 for 40 cycles -> tick[0] every 10 cycles, tick[1] every 5, tick[2] every 2; sq[2] period 4; each tick exactly 1 cycle wide.
REQ-033 start=1 for 7 cycles, start=0 for 20, start=1 -> tick[0] first asserts 3 cycles after resume; no ticks and sq frozen while start=0.
REQ-034 Write cfg_ch=1, cfg_div=3 on the edge where cnt[1]==4 -> no tick[1] that edge; next tick[1] 3 cycles later, then every 3 cycles; ch0/ch2 cadence undisturbed.
REQ-035 Write cfg_div=0 to ch2, then cfg_div=1 -> ch2 silent with sq[2] held, then tick[2] high every cycle and sq[2] toggling every cycle.
REQ-036 cfg_we=1, cfg_ch=3 -> cfg_err high exactly 1 cycle, all divisors and counters unchanged.
REQ-037 clear=1 and cfg_we=1 (ch0, div=4) on the same edge -> all cnt=0, sq=0, div[0]=4; rst=0 pulsed mid-period -> div back to {2,5,10}, outputs 0.

Source files
------------

// File: rtl/multi_rate_tick_gen.sv
// Multi-rate tick generator: NUM_CH independent programmable dividers, each
// producing a one-cycle tick and a square wave that toggles on every tick.
module multi_rate_tick_gen #(
  parameter int CNT_W = 27,
  parameter int NUM_CH = 3,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {27'd100000, 27'd50000000, 27'd100000000},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic              cfg_err
);

  // One extra bit so the range check stays meaningful when NUM_CH is a power of two.
  localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

  logic cfg_in_range;
  logic cfg_valid;

  assign cfg_in_range = ({1'b0, cfg_ch} < NUM_CH_V);
  assign cfg_valid    = cfg_we && cfg_in_range;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_in_range;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             sq_q;
    logic             wr_hit;
    logic             terminal;
    logic             enabled;

    assign wr_hit   = cfg_valid && (cfg_ch == CH_W'(i));
    assign enabled  = (div_q != '0);
    assign terminal = (cnt_q == div_q - CNT_W'(1));

    // Priority: reset, then clear, then a write to this channel, then counting.
    // A coincident clear still lets the divisor write land; only the restart is subsumed.
    always_ff @(posedge clk) begin
      if (!rst) begin
        div_q  <= DIV_INIT[i*CNT_W +: CNT_W];
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        if (wr_hit) begin
          div_q <= cfg_div;
        end
        if (clear) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
          sq_q   <= 1'b0;
        end else if (wr_hit) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
        end else if (start && enabled) begin
          if (terminal) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
            sq_q   <= ~sq_q;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
          if (!enabled) begin
            cnt_q <= '0;
          end
        end
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Directed bench for multi_rate_tick_gen with CNT_W=8, NUM_CH=3, divisors {2,5,10}:
// a table of per-edge vectors followed by hand-written multi-cycle sequences.
module tb_multi_rate_tick_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clear;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [2:0] tick;
  logic [2:0] sq;
  logic       cfg_err;

  int errors = 0;
  int checks = 0;

  multi_rate_tick_gen #(
    .CNT_W   (8),
    .NUM_CH  (3),
    .DIV_INIT({8'd2, 8'd5, 8'd10})
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .clear  (clear),
    .cfg_we (cfg_we),
    .cfg_ch (cfg_ch),
    .cfg_div(cfg_div),
    .tick   (tick),
    .sq     (sq),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       clr;
    logic       we;
    logic [1:0] ch;
    logic [7:0] dv;
    logic [2:0] exp_tick;
    logic [2:0] exp_sq;
    logic       exp_err;
  } vec_t;

  vec_t vecs [18];

  task automatic applyStimulus(input logic s, input logic c, input logic we,
                               input logic [1:0] ch, input logic [7:0] dv);
    start   = s;
    clear   = c;
    cfg_we  = we;
    cfg_ch  = ch;
    cfg_div = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs with start high until tick[ch] is seen; returns the edge count, or -1 on timeout.
  task automatic firstTick(input int ch, input int limit, output int edges);
    edges = -1;
    for (int k = 1; k <= limit; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
      if (tick[ch] === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] exp_t;
    logic [2:0] sq_m;
    logic [2:0] sq_hold;
    int         n;
    int         first0, first1, first2;
    int         tick_cnt, sq_changes;

    // Edges counted from reset release with start held high.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b100, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b100, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b010, 3'b010, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b110, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b110, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b010, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b010, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b101, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b101, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b001, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b001, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b001, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 2'd3, 8'd1, 3'b000, 3'b001, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b001, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 1'b0};

    // Reset must win over a coincident write and clear.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'd3);
    checkOutput("reset_tick", tick, 3'b000);
    checkOutput("reset_sq", sq, 3'b000);
    checkOutput("reset_err", cfg_err, 1'b0);
    rst = 1'b1;

    for (int v = 0; v < 18; v++) begin
      applyStimulus(vecs[v].st, vecs[v].clr, vecs[v].we, vecs[v].ch, vecs[v].dv);
      checkOutput($sformatf("vec%0d_tick", v), tick, vecs[v].exp_tick);
      checkOutput($sformatf("vec%0d_sq", v), sq, vecs[v].exp_sq);
      checkOutput($sformatf("vec%0d_err", v), cfg_err, vecs[v].exp_err);
    end

    // 40 free-running cycles from a clear: cadences 10/5/2 and square waves.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    sq_m = 3'b000;
    for (int e = 1; e <= 40; e++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
      exp_t = {(e % 2) == 0, (e % 5) == 0, (e % 10) == 0};
      sq_m  = sq_m ^ exp_t;
      checkOutput($sformatf("run40_tick_e%0d", e), tick, exp_t);
      checkOutput($sformatf("run40_sq_e%0d", e), sq, sq_m);
    end

    // Pause/resume: counts freeze while start is low.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    for (int e = 1; e <= 7; e++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    checkOutput("pause_sq_before", sq, 3'b110);
    sq_hold = sq;
    tick_cnt = 0;
    sq_changes = 0;
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
      if (tick !== 3'b000) tick_cnt++;
      if (sq !== sq_hold) sq_changes++;
    end
    checkOutput("pause_ticks", tick_cnt, 0);
    checkOutput("pause_sq_changes", sq_changes, 0);
    firstTick(0, 30, n);
    checkOutput("resume_first_tick0", n, 3);

    // Rewrite ch1 to 3 on the edge where its count is 4.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    for (int e = 1; e <= 4; e++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 8'd3);
    checkOutput("wr_edge_tick", tick, 3'b000);
    for (int e = 6; e <= 21; e++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
      exp_t = {(e % 2) == 0, (e >= 8) && (((e - 8) % 3) == 0), (e % 10) == 0};
      checkOutput($sformatf("wr_tick_e%0d", e), tick, exp_t);
    end

    // Divisor 0 silences ch2, divisor 1 ticks every cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 8'd0);
    checkOutput("div0_wr_tick2", tick[2], 1'b0);
    tick_cnt = 0;
    sq_changes = 0;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
      if (tick[2] !== 1'b0) tick_cnt++;
      if (sq[2] !== 1'b0) sq_changes++;
    end
    checkOutput("div0_ticks", tick_cnt, 0);
    checkOutput("div0_sq_changes", sq_changes, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 8'd1);
    checkOutput("div1_wr_tick2", tick[2], 1'b0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
      checkOutput($sformatf("div1_tick2_k%0d", k), tick[2], 1'b1);
      checkOutput($sformatf("div1_sq2_k%0d", k), sq[2], (k % 2) == 1);
    end

    // Out-of-range write: error pulse only, ch0/ch1 cadence kept.
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'd1);
    checkOutput("badch_err", cfg_err, 1'b1);
    checkOutput("badch_tick_e4", tick, 3'b100);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    checkOutput("badch_err_clr", cfg_err, 1'b0);
    checkOutput("badch_tick_e5", tick, 3'b010);
    for (int e = 6; e <= 10; e++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    checkOutput("badch_tick_e10", tick, 3'b111);

    // Clear plus write on one edge, then reset mid-period.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    for (int e = 1; e <= 3; e++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'd4);
    checkOutput("clrwr_tick", tick, 3'b000);
    checkOutput("clrwr_sq", sq, 3'b000);
    firstTick(0, 30, n);
    checkOutput("clrwr_first_tick0", n, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 8'd7);
    checkOutput("midrst_tick", tick, 3'b000);
    checkOutput("midrst_sq", sq, 3'b000);
    checkOutput("midrst_err", cfg_err, 1'b0);
    rst = 1'b1;
    first0 = -1;
    first1 = -1;
    first2 = -1;
    for (int e = 1; e <= 30; e++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
      if (tick[0] === 1'b1 && first0 < 0) first0 = e;
      if (tick[1] === 1'b1 && first1 < 0) first1 = e;
      if (tick[2] === 1'b1 && first2 < 0) first2 = e;
    end
    checkOutput("postrst_first_tick0", first0, 10);
    checkOutput("postrst_first_tick1", first1, 5);
    checkOutput("postrst_first_tick2", first2, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
